// File: rtl/ldpc_ctrl_pkg.sv
// Shared types and constants for the LDPC iteration controller.
// Holds the controller state encoding, default pipeline latencies and the address-width helper.
package ldpc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VNU,
        ST_VNU_DRAIN,
        ST_CNU,
        ST_CNU_DRAIN,
        ST_CHECK,
        ST_DONE
    } ctrl_state_t;

    localparam int DEF_VNU_LAT = 2;
    localparam int DEF_CNU_LAT = 2;

    // A depth of 1 still needs a 1-bit address port.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/en_addr_delay.sv
// Fixed-latency shift register carrying an enable strobe with its address.
// The output is the last register stage, so the delay is exactly DEPTH cycles.
module en_addr_delay #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_en,
    input  logic [AW-1:0] in_addr,
    output logic          out_en,
    output logic [AW-1:0] out_addr
);

    logic [AW:0] pipe_q [DEPTH];
    logic [AW:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = flush ? '0 : {in_en, in_addr};
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = flush ? '0 : pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign {out_en, out_addr} = pipe_q[DEPTH-1];

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for the layered LDPC decoder: load, VNU/CNU sweeps with
// latency-matched write-back, syndrome/limit termination and host handshake.
module ldpc_iter_ctrl
    import ldpc_ctrl_pkg::*;
#(
    parameter int N_COLS  = 32,
    parameter int N_ROWS  = 16,
    parameter int VNU_LAT = DEF_VNU_LAT,
    parameter int CNU_LAT = DEF_CNU_LAT,
    parameter int ITER_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ITER_W-1:0]           max_iter,
    input  logic                        abort,
    input  logic                        in_valid,
    input  logic                        syndrome_ok,
    output logic                        busy,
    output logic                        load_we,
    output logic [addr_w(N_COLS)-1:0]   load_addr,
    output logic                        vnu_en,
    output logic                        msg_clr,
    output logic [addr_w(N_COLS)-1:0]   col_addr,
    output logic                        vnu_wb_en,
    output logic [addr_w(N_COLS)-1:0]   vnu_wb_addr,
    output logic                        cnu_en,
    output logic [addr_w(N_ROWS)-1:0]   row_addr,
    output logic                        cnu_wb_en,
    output logic [addr_w(N_ROWS)-1:0]   cnu_wb_addr,
    output logic [ITER_W-1:0]           iter_count,
    output logic                        done,
    output logic                        converged
);

    localparam int CAW = addr_w(N_COLS);
    localparam int RAW = addr_w(N_ROWS);
    localparam logic [CAW-1:0] COL_LAST = CAW'(N_COLS - 1);
    localparam logic [RAW-1:0] ROW_LAST = RAW'(N_ROWS - 1);

    ctrl_state_t       state_q, state_d;
    logic [ITER_W-1:0] limit_q, limit_d;
    logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
    logic [CAW-1:0]    load_cnt_q, load_cnt_d;
    logic [CAW-1:0]    load_addr_q, load_addr_d;
    logic [CAW-1:0]    col_addr_q, col_addr_d;
    logic [RAW-1:0]    row_addr_q, row_addr_d;
    logic              load_we_q, load_we_d;
    logic              vnu_en_q, vnu_en_d;
    logic              msg_clr_q, msg_clr_d;
    logic              cnu_en_q, cnu_en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              conv_q, conv_d;

    assign iter_inc = (&iter_q) ? iter_q : iter_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        iter_d      = iter_q;
        conv_d      = conv_q;
        load_cnt_d  = load_cnt_q;
        load_addr_d = load_addr_q;
        load_we_d   = 1'b0;
        col_addr_d  = col_addr_q;
        row_addr_d  = row_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    limit_d    = (max_iter == '0) ? ITER_W'(1) : max_iter;
                    iter_d     = '0;
                    conv_d     = 1'b0;
                    load_cnt_d = '0;
                end
            end
            // The write strobe lags in_valid by one register; LOAD ends when the last write is visible.
            ST_LOAD: begin
                if (load_we_q && load_addr_q == COL_LAST) begin
                    state_d    = ST_VNU;
                    col_addr_d = '0;
                end else if (in_valid) begin
                    load_we_d   = 1'b1;
                    load_addr_d = load_cnt_q;
                    load_cnt_d  = load_cnt_q + 1'b1;
                end
            end
            ST_VNU: begin
                if (col_addr_q == COL_LAST) state_d = ST_VNU_DRAIN;
                else                        col_addr_d = col_addr_q + 1'b1;
            end
            ST_VNU_DRAIN: begin
                if (vnu_wb_en && vnu_wb_addr == COL_LAST) begin
                    state_d    = ST_CNU;
                    row_addr_d = '0;
                end
            end
            ST_CNU: begin
                if (row_addr_q == ROW_LAST) state_d = ST_CNU_DRAIN;
                else                        row_addr_d = row_addr_q + 1'b1;
            end
            ST_CNU_DRAIN: begin
                if (cnu_wb_en && cnu_wb_addr == ROW_LAST) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                iter_d = iter_inc;
                if (syndrome_ok) begin
                    conv_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (iter_inc == limit_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_VNU;
                    col_addr_d = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort freezes all bookkeeping and drops straight back to IDLE.
        if (abort) begin
            state_d     = ST_IDLE;
            limit_d     = limit_q;
            iter_d      = iter_q;
            conv_d      = conv_q;
            load_cnt_d  = load_cnt_q;
            load_addr_d = load_addr_q;
            load_we_d   = 1'b0;
            col_addr_d  = col_addr_q;
            row_addr_d  = row_addr_q;
        end
        vnu_en_d  = (state_d == ST_VNU);
        msg_clr_d = vnu_en_d && (iter_d == '0);
        cnu_en_d  = (state_d == ST_CNU);
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            limit_q     <= '0;
            iter_q      <= '0;
            conv_q      <= 1'b0;
            load_cnt_q  <= '0;
            load_addr_q <= '0;
            load_we_q   <= 1'b0;
            col_addr_q  <= '0;
            row_addr_q  <= '0;
            vnu_en_q    <= 1'b0;
            msg_clr_q   <= 1'b0;
            cnu_en_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            iter_q      <= iter_d;
            conv_q      <= conv_d;
            load_cnt_q  <= load_cnt_d;
            load_addr_q <= load_addr_d;
            load_we_q   <= load_we_d;
            col_addr_q  <= col_addr_d;
            row_addr_q  <= row_addr_d;
            vnu_en_q    <= vnu_en_d;
            msg_clr_q   <= msg_clr_d;
            cnu_en_q    <= cnu_en_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    en_addr_delay #(.DEPTH(VNU_LAT), .AW(CAW)) u_vnu_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .in_en    (vnu_en_q),
        .in_addr  (col_addr_q),
        .out_en   (vnu_wb_en),
        .out_addr (vnu_wb_addr)
    );

    en_addr_delay #(.DEPTH(CNU_LAT), .AW(RAW)) u_cnu_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .in_en    (cnu_en_q),
        .in_addr  (row_addr_q),
        .out_en   (cnu_wb_en),
        .out_addr (cnu_wb_addr)
    );

    assign busy       = busy_q;
    assign load_we    = load_we_q;
    assign load_addr  = load_addr_q;
    assign vnu_en     = vnu_en_q;
    assign msg_clr    = msg_clr_q;
    assign col_addr   = col_addr_q;
    assign cnu_en     = cnu_en_q;
    assign row_addr   = row_addr_q;
    assign iter_count = iter_q;
    assign done       = done_q;
    assign converged  = conv_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Scoreboard bench for ldpc_iter_ctrl: a frame-level model predicts every strobe event,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ldpc_iter_ctrl;

    localparam int N  = 4;
    localparam int R  = 2;
    localparam int VL = 2;
    localparam int CL = 2;
    localparam int IW = 4;
    localparam int IT = N + VL + R + CL + 1;

    localparam int K_LOAD = 0, K_VNU = 1, K_VWB = 2, K_CNU = 3, K_CWB = 4, K_DONE = 5;

    typedef struct {
        int cyc;
        int kind;
        int addr;
        bit mc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, in_valid, syndrome_ok;
    logic [IW-1:0] max_iter;
    logic          busy, load_we, vnu_en, msg_clr, vnu_wb_en, cnu_en, cnu_wb_en, done, converged;
    logic [1:0]    load_addr, col_addr, vnu_wb_addr;
    logic [0:0]    row_addr, cnu_wb_addr;
    logic [IW-1:0] iter_count;

    ev_t sb[$];
    bit  fix_pat[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  bfrom = 1, bto = 0;
    bit  mon_en = 1'b0;

    logic [22:0] all_outs;
    logic [5:0]  strobes;
    assign all_outs = {busy, load_we, load_addr, vnu_en, msg_clr, col_addr, vnu_wb_en, vnu_wb_addr,
                       cnu_en, row_addr, cnu_wb_en, cnu_wb_addr, iter_count, done, converged};
    assign strobes  = {load_we, vnu_en, vnu_wb_en, cnu_en, cnu_wb_en, done};

    ldpc_iter_ctrl #(.N_COLS(N), .N_ROWS(R), .VNU_LAT(VL), .CNU_LAT(CL), .ITER_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter), .abort(abort),
        .in_valid(in_valid), .syndrome_ok(syndrome_ok), .busy(busy), .load_we(load_we),
        .load_addr(load_addr), .vnu_en(vnu_en), .msg_clr(msg_clr), .col_addr(col_addr),
        .vnu_wb_en(vnu_wb_en), .vnu_wb_addr(vnu_wb_addr), .cnu_en(cnu_en), .row_addr(row_addr),
        .cnu_wb_en(cnu_wb_en), .cnu_wb_addr(cnu_wb_addr), .iter_count(iter_count), .done(done),
        .converged(converged)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic string kname(input int k);
        case (k)
            K_LOAD:  return "load_we";
            K_VNU:   return "vnu_en";
            K_VWB:   return "vnu_wb_en";
            K_CNU:   return "cnu_en";
            K_CWB:   return "cnu_wb_en";
            default: return "done";
        endcase
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic sb_check(input int kind, input int addr, input bit mc);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_%s at cycle %0d: addr=%0d, no event expected", kname(kind), cyc, addr);
            return;
        end
        e = sb.pop_front();
        if (e.cyc == cyc && e.kind == kind && e.addr == addr && e.mc == mc) n_pass++;
        else $display("FAIL %s: got cyc=%0d addr=%0d msg_clr=%0d, expected %s cyc=%0d addr=%0d msg_clr=%0d",
                      kname(kind), cyc, addr, mc, kname(e.kind), e.cyc, e.addr, e.mc);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk(busy == (cyc >= bfrom && cyc <= bto), "busy", busy, (cyc >= bfrom && cyc <= bto));
            chk(!(msg_clr && !vnu_en), "msg_clr_without_vnu_en", msg_clr, 0);
            if (load_we)   sb_check(K_LOAD, int'(load_addr), 1'b0);
            if (vnu_en)    sb_check(K_VNU, int'(col_addr), msg_clr);
            if (vnu_wb_en) sb_check(K_VWB, int'(vnu_wb_addr), 1'b0);
            if (cnu_en)    sb_check(K_CNU, int'(row_addr), 1'b0);
            if (cnu_wb_en) sb_check(K_CWB, int'(cnu_wb_addr), 1'b0);
            if (done)      sb_check(K_DONE, 0, 1'b0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input int k, input int a, input bit m);
        ev_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.mc = m;
        sb.push_back(e);
    endtask

    // cut: 0 none, 1 abort during CNU of iteration cut_iter, 2 reset during VNU of iteration cut_iter
    task automatic run_frame(input int mi, input int dens, input int syn_mask,
                             input int cut, input int cut_iter, input int cut_off);
        int  A, L, V0, lim, f, X, fin, a, w, c, it, off, o2, iter_exp;
        int  ld[N];
        bit  vin[$];
        bit  conv_exp;
        next_cycle();
        A = cyc + 1;
        w = 0;
        c = A;
        while (w < N) begin
            bit v;
            if (fix_pat.size() > 0) v = fix_pat.pop_front();
            else                    v = ($urandom_range(99) < dens);
            vin.push_back(v);
            if (v) begin
                ld[w] = c + 1;
                w++;
            end
            c++;
        end
        fix_pat.delete();
        L   = ld[N-1];
        V0  = L + 1;
        lim = (mi == 0) ? 1 : mi;
        f   = lim - 1;
        for (int i = lim - 1; i >= 0; i--) if (syn_mask[i]) f = i;
        conv_exp = syn_mask[f];
        iter_exp = f + 1;
        a = cut_iter % (f + 1);
        X = 0;
        if (cut == 1) X = V0 + a * IT + N + VL + (cut_off % R);
        if (cut == 2) X = V0 + a * IT + (cut_off % N);
        fin = (cut != 0) ? X : V0 + f * IT + IT;

        for (c = A + 1; c <= fin; c++) begin
            for (int k = 0; k < N; k++) if (ld[k] == c) push_ev(c, K_LOAD, k, 1'b0);
            if (c >= V0) begin
                it  = (c - V0) / IT;
                off = (c - V0) % IT;
                o2  = off - N - VL;
                if (it <= f) begin
                    if (off < N)                    push_ev(c, K_VNU, off, it == 0);
                    if (off >= VL && off < VL + N)  push_ev(c, K_VWB, off - VL, 1'b0);
                    if (o2 >= 0 && o2 < R)          push_ev(c, K_CNU, o2, 1'b0);
                    if (o2 >= CL && o2 < CL + R)    push_ev(c, K_CWB, o2 - CL, 1'b0);
                end
            end
            if (cut == 0 && c == fin) push_ev(c, K_DONE, 0, 1'b0);
        end
        bfrom = A;
        bto   = fin;

        for (c = A - 1; c <= fin; c++) begin
            if (c != A - 1) next_cycle();
            start       = (c == A - 1) ? 1'b1 : 1'($urandom_range(3) == 0);
            max_iter    = (c == A - 1) ? IW'(mi) : IW'($urandom_range(15));
            in_valid    = (c >= A && c - A < vin.size()) ? vin[c - A] : 1'($urandom_range(1));
            syndrome_ok = 1'($urandom_range(1));
            for (int i = 0; i <= f; i++) if (c == V0 + i * IT + IT - 1) syndrome_ok = syn_mask[i];
            abort       = (cut == 1 && c == X);
        end

        if (cut == 2) begin
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            start = 1'b0;
            abort = 1'b0;
            #1;
            chk(all_outs == '0, "outputs_in_reset", all_outs, 0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            next_cycle();
            chk(iter_count == 0, "iter_after_reset", iter_count, 0);
        end else begin
            next_cycle();
            start = 1'b0;
            abort = 1'b0;
            chk(busy == 1'b0, "busy_after_end", busy, 0);
            if (cut == 1) begin
                chk(strobes == '0, "strobes_after_abort", strobes, 0);
                chk(iter_count == IW'(a), "iter_after_abort", iter_count, a);
                chk(converged == 1'b0, "conv_after_abort", converged, 0);
            end else begin
                chk(iter_count == IW'(iter_exp), "iter_count", iter_count, iter_exp);
                chk(converged == conv_exp, "converged", converged, conv_exp);
            end
        end

        repeat ($urandom_range(4, 2)) begin
            next_cycle();
            in_valid    = 1'($urandom_range(1));
            syndrome_ok = 1'($urandom_range(1));
        end
        chk(sb.size() == 0, "events_outstanding", sb.size(), 0);
        if (cut == 0) chk(converged == conv_exp, "converged_held", converged, conv_exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        syndrome_ok = 1'b0;
        max_iter    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(all_outs == '0, "reset_state", all_outs, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_frame(3, 100, 0, 0, 0, 0);
        run_frame(3, 100, 'b010, 0, 0, 0);
        fix_pat = '{1, 0, 0, 1, 1, 0, 1};
        run_frame(3, 100, 0, 0, 0, 0);
        run_frame(3, 100, 0, 1, 1, 0);
        run_frame(3, 100, 0, 0, 0, 0);
        run_frame(3, 100, 0, 2, 0, 2);
        run_frame(3, 100, 0, 0, 0, 0);
        run_frame(0, 100, 0, 0, 0, 0);

        for (int n = 0; n < 12; n++) begin
            int cut_k;
            int syn;
            cut_k = $urandom_range(4);
            if (cut_k > 2) cut_k = 0;
            syn = ($urandom_range(2) == 0) ? (1 << $urandom_range(4)) : 0;
            run_frame($urandom_range(4), $urandom_range(100, 30), syn, cut_k,
                      $urandom_range(7), $urandom_range(7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
